pipelined_cpa: RTL and testbench



---
 rtl/pipelined_cpa_pkg.sv | 13 +
 rtl/pipelined_cpa_if.sv | 36 +++
 rtl/pipelined_cpa_segment.sv | 45 ++++
 rtl/pipelined_cpa.sv | 141 ++++++++++++++
 tb/tb_pipelined_cpa.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_cpa_pkg.sv
// Shared constants for the FMA datapath: mantissa product widths and the CPA segmenting helper.
package fma_pkg;

    localparam int MANT_PROD_W_SP = 48;
    localparam int MANT_PROD_W_DP = 106;
    localparam int CPA_SEG_W      = 16;

    // Number of pipeline stages of the carry-propagate adder; width must divide evenly.
    function automatic int cpa_num_seg(input int width, input int seg_w);
        return width / seg_w;
    endfunction

endpackage

// File: rtl/pipelined_cpa_if.sv
// Operand/result handshake bundle of the pipelined carry-propagate adder.
// res_zero exists only when CPA_ZERO_FLAG_EN is defined.
interface pipelined_cpa_if
    import fma_pkg::*;
#(
    parameter int WIDTH = MANT_PROD_W_SP
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] s_vec;
    logic [WIDTH-1:0] c_vec;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   result;
`ifdef CPA_ZERO_FLAG_EN
    logic             res_zero;
`endif

    modport master (
        output in_valid, s_vec, c_vec, out_ready,
`ifdef CPA_ZERO_FLAG_EN
        input  res_zero,
`endif
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, s_vec, c_vec, out_ready,
`ifdef CPA_ZERO_FLAG_EN
        output res_zero,
`endif
        output in_ready, out_valid, result
    );

endinterface

// File: rtl/pipelined_cpa_segment.sv
// One SEG_W-bit slice of the pipelined CPA: registered sum, carry-out, valid and
// (with CPA_ZERO_FLAG_EN) running zero flag, all frozen while stall is high.
module cpa_segment #(
    parameter int SEG_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    input  logic             valid_in,
`ifdef CPA_ZERO_FLAG_EN
    input  logic             zero_in,
    output logic             zero_reg,
`endif
    output logic [SEG_W-1:0] sum_reg,
    output logic             cout_reg,
    output logic             valid_reg
);

    logic [SEG_W:0] sum_next;

    assign sum_next = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, cin};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            valid_reg <= 1'b0;
`ifdef CPA_ZERO_FLAG_EN
            zero_reg  <= 1'b0;
`endif
        end else if (!stall) begin
            sum_reg   <= sum_next[SEG_W-1:0];
            cout_reg  <= sum_next[SEG_W];
            valid_reg <= valid_in;
`ifdef CPA_ZERO_FLAG_EN
            // Zero-so-far across the segments resolved up to and including this one.
            zero_reg  <= zero_in & (sum_next[SEG_W-1:0] == '0);
`endif
        end
    end

endmodule

// File: rtl/pipelined_cpa.sv
// Segmented, pipelined carry-propagate adder resolving compressor sum/carry vectors,
// one SEG_W slice per stage, global stall. Optional zero flag: CPA_ZERO_FLAG_EN.
module pipelined_cpa
    import fma_pkg::*;
#(
    parameter int WIDTH = MANT_PROD_W_SP,
    parameter int SEG_W = CPA_SEG_W
) (
    input  logic            clk,
    input  logic            rst_n,
    pipelined_cpa_if.slave  bus
);

    localparam int NUM_SEG = cpa_num_seg(WIDTH, SEG_W);

    logic stall;
    logic accept;

    logic [SEG_W-1:0] seg_sum   [NUM_SEG];
    logic             seg_cout  [NUM_SEG];
    logic             seg_valid [NUM_SEG];
`ifdef CPA_ZERO_FLAG_EN
    logic             seg_zero  [NUM_SEG];
`endif

    // Row = stage, column = segment. Skew rows carry not-yet-added upper segments,
    // lo_res rows carry already-resolved lower segments.
    logic [SEG_W-1:0] s_skew [NUM_SEG][NUM_SEG];
    logic [SEG_W-1:0] c_skew [NUM_SEG][NUM_SEG];
    logic [SEG_W-1:0] lo_res [NUM_SEG][NUM_SEG];

    logic [WIDTH:0]   result_w;

    assign stall        = seg_valid[NUM_SEG-1] & ~bus.out_ready;
    assign accept       = bus.in_valid & ~stall;
    assign bus.in_ready = ~stall;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SEG; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                cpa_segment #(.SEG_W(SEG_W)) u_seg (
                    .clk       (clk),
                    .rst_n     (rst_n),
                    .stall     (stall),
                    .a         (bus.s_vec[SEG_W-1:0]),
                    .b         (bus.c_vec[SEG_W-1:0]),
                    .cin       (1'b0),
                    .valid_in  (accept),
`ifdef CPA_ZERO_FLAG_EN
                    .zero_in   (1'b1),
                    .zero_reg  (seg_zero[gi]),
`endif
                    .sum_reg   (seg_sum[gi]),
                    .cout_reg  (seg_cout[gi]),
                    .valid_reg (seg_valid[gi])
                );

                if (NUM_SEG > 1) begin : g_skew
                    always_ff @(posedge clk or negedge rst_n) begin
                        if (!rst_n) begin
                            for (int j = 1; j < NUM_SEG; j++) begin
                                s_skew[gi][j] <= '0;
                                c_skew[gi][j] <= '0;
                            end
                        end else if (!stall) begin
                            for (int j = 1; j < NUM_SEG; j++) begin
                                s_skew[gi][j] <= bus.s_vec[j*SEG_W +: SEG_W];
                                c_skew[gi][j] <= bus.c_vec[j*SEG_W +: SEG_W];
                            end
                        end
                    end
                end
            end else begin : g_rest
                cpa_segment #(.SEG_W(SEG_W)) u_seg (
                    .clk       (clk),
                    .rst_n     (rst_n),
                    .stall     (stall),
                    .a         (s_skew[gi-1][gi]),
                    .b         (c_skew[gi-1][gi]),
                    .cin       (seg_cout[gi-1]),
                    .valid_in  (seg_valid[gi-1]),
`ifdef CPA_ZERO_FLAG_EN
                    .zero_in   (seg_zero[gi-1]),
                    .zero_reg  (seg_zero[gi]),
`endif
                    .sum_reg   (seg_sum[gi]),
                    .cout_reg  (seg_cout[gi]),
                    .valid_reg (seg_valid[gi])
                );

                // Lower segments ride along unchanged; the newest one comes from the previous adder.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        for (int j = 0; j < gi; j++) begin
                            lo_res[gi][j] <= '0;
                        end
                    end else if (!stall) begin
                        for (int j = 0; j < gi; j++) begin
                            lo_res[gi][j] <= (j == gi - 1) ? seg_sum[gi-1] : lo_res[gi-1][j];
                        end
                    end
                end

                if (gi < NUM_SEG - 1) begin : g_skew
                    always_ff @(posedge clk or negedge rst_n) begin
                        if (!rst_n) begin
                            for (int j = gi + 1; j < NUM_SEG; j++) begin
                                s_skew[gi][j] <= '0;
                                c_skew[gi][j] <= '0;
                            end
                        end else if (!stall) begin
                            for (int j = gi + 1; j < NUM_SEG; j++) begin
                                s_skew[gi][j] <= s_skew[gi-1][j];
                                c_skew[gi][j] <= c_skew[gi-1][j];
                            end
                        end
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        result_w = '0;
        for (int j = 0; j < NUM_SEG; j++) begin
            result_w[j*SEG_W +: SEG_W] = (j == NUM_SEG - 1) ? seg_sum[NUM_SEG-1]
                                                            : lo_res[NUM_SEG-1][j];
        end
        result_w[WIDTH] = seg_cout[NUM_SEG-1];
    end

    assign bus.result    = result_w;
    assign bus.out_valid = seg_valid[NUM_SEG-1];

`ifdef CPA_ZERO_FLAG_EN
    // The final carry-out is the MSB of the result, so it must also be clear.
    assign bus.res_zero = seg_zero[NUM_SEG-1] & ~seg_cout[NUM_SEG-1];
`endif

endmodule

// File: tb/tb_pipelined_cpa.sv
// Self-checking bench for pipelined_cpa: directed vector table, multi-cycle corner
// sequences and a randomized run against a queue-based arithmetic model.
module tb_pipelined_cpa;
    import fma_pkg::*;

    localparam int WIDTH = 48;
    localparam int SEG_W = 16;
    localparam int LAT   = WIDTH / SEG_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pipelined_cpa_if #(.WIDTH(WIDTH)) bus ();

    pipelined_cpa #(.WIDTH(WIDTH), .SEG_W(SEG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [WIDTH:0] exp;
        int             acc_cyc;
        bit             chk_lat;
    } pend_t;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] c;
        logic [WIDTH:0]   exp;
    } vec_t;

    pend_t          pend_q[$];
    int             total = 0;
    int             bad   = 0;
    int             cyc   = 0;
    logic [WIDTH:0] drv_exp;
    bit             lat_check;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [WIDTH-1:0] rand48();
        return {16'($urandom), $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c);
        bus.in_valid = v;
        bus.s_vec    = s;
        bus.c_vec    = c;
        drv_exp      = {1'b0, s} + {1'b0, c};
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard: record accepts, retire results in acceptance order.
    always @(negedge clk) begin : monitor
        pend_t p;
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                if (pend_q.size() == 0) begin
                    check("stale_result", 64'(bus.out_valid), 64'd0);
                end else begin
                    p = pend_q.pop_front();
                    $display("txn cyc=%0d result=%h expected=%h", cyc, bus.result, p.exp);
                    check("result", 64'(bus.result), 64'(p.exp));
`ifdef CPA_ZERO_FLAG_EN
                    check("res_zero", 64'(bus.res_zero), 64'(p.exp == '0));
`endif
                    if (p.chk_lat) check("latency", 64'(cyc - p.acc_cyc), 64'(LAT));
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                pend_q.push_back('{drv_exp, cyc, lat_check});
            end
        end
    end

    initial begin
        vec_t             tbl [6];
        logic [WIDTH:0]   sexp [4];
        logic [WIDTH-1:0] rs, rc;
        bit               hist [16];

        tbl[0] = '{48'h1,              48'h2,              49'h3};
        tbl[1] = '{48'h8000_0000_0000, 48'h8000_0000_0000, 49'h1_0000_0000_0000};
        tbl[2] = '{48'h1234,           48'hFFFF,           49'h11233};
        tbl[3] = '{48'h0,              48'h0,              49'h0};
        tbl[4] = '{48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 49'h1_FFFF_FFFF_FFFE};
        tbl[5] = '{48'h0000_FFFF_0000, 48'h0000_0001_0000, 49'h0_0001_0000_0000};

        bus.in_valid  = 1'b0;
        bus.s_vec     = '0;
        bus.c_vec     = '0;
        bus.out_ready = 1'b0;
        drv_exp       = '0;
        lat_check     = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_result",    64'(bus.result),    64'd0);
`ifdef CPA_ZERO_FLAG_EN
        check("rst_res_zero",  64'(bus.res_zero),  64'd0);
`endif
        @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        tick();

        // Carry ripples through every segment
        drive(1'b1, 48'hFFFF_FFFF_FFFF, 48'h0000_0000_0001);
        tick();
        drive(1'b0, '0, '0);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            check("ripple_valid", 64'(bus.out_valid), 64'(k == LAT));
            if (k == LAT) check("ripple_result", 64'(bus.result), 64'h1_0000_0000_0000);
        end
        tick();

        // Directed table, back to back
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, tbl[i].s, tbl[i].c);
            drv_exp = tbl[i].exp;
            tick();
        end
        drive(1'b0, '0, '0);
        repeat (5) tick();

        // Stall with three in flight and a fourth waiting
        lat_check     = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rs = rand48();
            rc = rand48();
            sexp[i] = {1'b0, rs} + {1'b0, rc};
            drive(1'b1, rs, rc);
            if (i < 3) tick();
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(bus.in_ready),  64'd0);
            check("stall_valid",    64'(bus.out_valid), 64'd1);
            check("stall_hold",     64'(bus.result),    64'(sexp[0]));
        end
        tick();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("release_valid", 64'(bus.out_valid), 64'd1);
            check("release_order", 64'(bus.result), 64'(sexp[k]));
            tick();
            if (k == 0) drive(1'b0, '0, '0);
        end
        @(negedge clk);
        check("release_empty", 64'(bus.out_valid), 64'd0);
        lat_check = 1'b1;
        tick();

        // Alternating in_valid shows up on out_valid LAT cycles later
        for (int i = 0; i < 16; i++) begin
            drive((i % 2) == 0, rand48(), rand48());
            @(negedge clk);
            hist[i] = bus.in_valid;
            if (i >= LAT) check("alt_valid", 64'(bus.out_valid), 64'(hist[i-LAT]));
            tick();
        end
        drive(1'b0, '0, '0);
        repeat (5) tick();

        // Asynchronous reset with operands in flight
        bus.out_ready = 1'b0;
        drive(1'b1, rand48(), rand48());
        tick();
        drive(1'b1, rand48(), rand48());
        tick();
        drive(1'b0, '0, '0);
        tick();
        check("pre_rst_valid", 64'(bus.out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        pend_q.delete();
        #1;
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("mid_rst_result",    64'(bus.result),    64'd0);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("post_rst_idle", 64'(bus.out_valid), 64'd0);
        end
        tick();
        drive(1'b1, 48'h0000_0000_FFFF, 48'h0000_0000_0001);
        tick();
        drive(1'b0, '0, '0);
        repeat (5) tick();

        // Randomized traffic with random backpressure
        lat_check = 1'b0;
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 9) < 7, rand48(), rand48());
            bus.out_ready = $urandom_range(0, 9) < 7;
            tick();
        end
        drive(1'b0, '0, '0);
        bus.out_ready = 1'b1;
        repeat (8) tick();
        check("drain_empty", 64'(pend_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
